// File: rtl/axi_rd_slave_mem.sv
// axi_rd_slave_mem: AXI4 read-channel slave backed by a word-addressed array.
// Accepts one AR request at a time and streams the R burst (FIXED/INCR/WRAP).
// A backdoor write port preloads the array for test setup.
// Optional macro RD_SLV_WAIT_EN inserts WAIT_CYCLES idle cycles before every beat.
module axi_rd_slave_mem #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     ARVALID,
  input  logic [7:0]               ARID,
  input  logic [31:0]              ARADDR,
  input  logic [7:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  output logic                     ARREADY,
  input  logic                     RREADY,
  output logic                     RVALID,
  output logic [7:0]               RID,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  input  logic                     bd_we,
  input  logic [$clog2(DEPTH)-1:0] bd_addr,
  input  logic [31:0]              bd_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef RD_SLV_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, WAIT = 2'd2} state_t;
  localparam bit UseWait = (WAIT_CYCLES != 0);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1} state_t;
`endif

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];

  logic        arready_q;
  logic        rvalid_q;
  logic [7:0]  rid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rlast_q;

  logic [7:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic        err_q;
  logic [7:0]  beat_q;

  logic        ar_hs;
  logic        r_hs;
  logic        ar_err;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic [31:0] next_addr;

  logic        latch_ar;
  logic        step;
  logic        load;
  logic        drop;
  logic [31:0] load_addr;
  logic        load_err;
  logic [7:0]  load_beat;
  logic [7:0]  load_len;
  logic [7:0]  load_id;

  logic [31:0] load_off;
  logic        load_oor;
  logic [AW-1:0] load_idx;
  logic [31:0] load_word;

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

  assign ar_hs = ARVALID & arready_q;
  assign r_hs  = rvalid_q & RREADY;

  assign ar_err = (ARSIZE != 3'b010) ||
                  (ARBURST == 2'b11) ||
                  ((ARBURST == 2'b10) && !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                  (ARADDR[1:0] != 2'b00);

  assign incr_addr = addr_q + 32'd4;
  assign wrap_mask = ((({24'd0, len_q}) + 32'd1) << 2) - 32'd1;

  // Address of the beat following the current one, by burst type
  always_comb begin
    next_addr = incr_addr;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  assign load_off  = load_addr - BASE_ADDR;
  assign load_oor  = (load_addr < BASE_ADDR) || ((load_off >> 2) >= DEPTH);
  assign load_idx  = load_off[AW+1:2];
  assign load_word = mem[load_idx];

  // Backdoor preload; a beat loaded on the same edge sees the old word
  always_ff @(posedge ACLK) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

`ifdef RD_SLV_WAIT_EN
  logic [31:0] wait_q;
  logic        wait_done;
  assign wait_done = (wait_q == WAIT_CYCLES - 1);

  // Counts idle cycles spent in WAIT before the next beat is presented
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                               wait_q <= '0;
    else if (state_q == WAIT && state_d == WAIT) wait_q <= wait_q + 32'd1;
    else                                        wait_q <= '0;
  end
`endif

  // State register; ARREADY is high exactly while the FSM sits in IDLE
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == IDLE);
    end
  end

  // Next-state decode and beat-load control
  always_comb begin
    state_d   = state_q;
    latch_ar  = 1'b0;
    step      = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
    load_addr = addr_q;
    load_err  = err_q;
    load_beat = beat_q;
    load_len  = len_q;
    load_id   = id_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          latch_ar = 1'b1;
          state_d  = BURST;
`ifdef RD_SLV_WAIT_EN
          if (UseWait) state_d = WAIT;
          else         load    = 1'b1;
`else
          load = 1'b1;
`endif
          load_addr = ARADDR;
          load_err  = ar_err;
          load_beat = 8'd0;
          load_len  = ARLEN;
          load_id   = ARID;
        end
      end
      BURST: begin
        if (r_hs) begin
          if (rlast_q) begin
            drop    = 1'b1;
            state_d = IDLE;
          end else begin
            step      = 1'b1;
            load_addr = next_addr;
            load_beat = beat_q + 8'd1;
`ifdef RD_SLV_WAIT_EN
            if (UseWait) begin
              drop    = 1'b1;
              state_d = WAIT;
            end else begin
              load = 1'b1;
            end
`else
            load = 1'b1;
`endif
          end
        end
      end
`ifdef RD_SLV_WAIT_EN
      WAIT: begin
        if (wait_done) begin
          load    = 1'b1;
          state_d = BURST;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Burst context and registered R outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      if (latch_ar) begin
        id_q    <= ARID;
        addr_q  <= ARADDR;
        len_q   <= ARLEN;
        burst_q <= ARBURST;
        err_q   <= ar_err;
        beat_q  <= 8'd0;
      end else if (step) begin
        addr_q <= next_addr;
        beat_q <= beat_q + 8'd1;
      end
      if (load) begin
        rvalid_q <= 1'b1;
        rid_q    <= load_id;
        rdata_q  <= (load_err || load_oor) ? 32'd0 : load_word;
        rresp_q  <= (load_err || load_oor) ? 2'b10 : 2'b00;
        rlast_q  <= (load_beat == load_len);
      end else if (drop) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// tb_axi_rd_slave_mem: directed, table-driven bench for axi_rd_slave_mem
// in its default build (no wait cycles), plus stall, backdoor and reset sequences.
module tb_axi_rd_slave_mem;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          ARVALID;
  logic [7:0]    ARID;
  logic [31:0]   ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARREADY;
  logic          RREADY;
  logic          RVALID;
  logic [7:0]    RID;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_wdata;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic [7:0]        id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                beats;
    logic [3:0][31:0]  data;
    logic [3:0][1:0]   resp;
  } vec_t;

  vec_t vecs [12];

  axi_rd_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(ARVALID), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARREADY(ARREADY),
    .RREADY(RREADY), .RVALID(RVALID), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input int i, input logic [7:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                        input int beats,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [1:0] r0, input logic [1:0] r1,
                        input logic [1:0] r2, input logic [1:0] r3);
    vecs[i].id    = id;
    vecs[i].addr  = addr;
    vecs[i].len   = len;
    vecs[i].size  = size;
    vecs[i].burst = burst;
    vecs[i].beats = beats;
    vecs[i].data  = {d3, d2, d1, d0};
    vecs[i].resp  = {r3, r2, r1, r0};
  endtask

  task automatic backdoorWrite(input int idx, input logic [31:0] val);
    bd_we    = 1'b1;
    bd_addr  = AW'(idx);
    bd_wdata = val;
    @(posedge ACLK); #1;
    bd_we    = 1'b0;
  endtask

  // Waits for ARREADY, issues the AR, then checks every beat with RREADY held high
  task automatic applyStimulus(input vec_t v, input int idx);
    int guard = 0;
    while (ARREADY !== 1'b1 && guard < 20) begin
      @(posedge ACLK); #1;
      guard++;
    end
    checkOutput($sformatf("v%0d arready_idle", idx), ARREADY, 32'd1);
    ARVALID = 1'b1;
    ARID    = v.id;
    ARADDR  = v.addr;
    ARLEN   = v.len;
    ARSIZE  = v.size;
    ARBURST = v.burst;
    RREADY  = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    for (int b = 0; b < v.beats; b++) begin
      @(negedge ACLK);
      checkOutput($sformatf("v%0d b%0d rvalid", idx, b), RVALID, 32'd1);
      checkOutput($sformatf("v%0d b%0d rdata", idx, b), RDATA, v.data[b]);
      checkOutput($sformatf("v%0d b%0d rresp", idx, b), RRESP, v.resp[b]);
      checkOutput($sformatf("v%0d b%0d rlast", idx, b), RLAST, (b == v.beats - 1));
      checkOutput($sformatf("v%0d b%0d rid", idx, b), RID, v.id);
      if (b == 0) checkOutput($sformatf("v%0d arready_busy", idx), ARREADY, 32'd0);
      @(posedge ACLK); #1;
    end
    @(negedge ACLK);
    checkOutput($sformatf("v%0d rvalid_after", idx), RVALID, 32'd0);
    checkOutput($sformatf("v%0d arready_after", idx), ARREADY, 32'd1);
  endtask

  initial begin
    ARESETn  = 1'b0;
    ARVALID  = 1'b0;
    ARID     = '0;
    ARADDR   = '0;
    ARLEN    = '0;
    ARSIZE   = 3'b010;
    ARBURST  = 2'b01;
    RREADY   = 1'b0;
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_wdata = '0;

    //          i  id     addr    len  size    burst  n  d0/d1/d2/d3                                             r0..r3
    addVec(0,  8'h5C, 32'h000, 8'd3, 3'b010, 2'b01, 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3,             2'b00, 2'b00, 2'b00, 2'b00);
    addVec(1,  8'h11, 32'h008, 8'd3, 3'b010, 2'b10, 4, 32'hA2, 32'hA3, 32'hA0, 32'hA1,             2'b00, 2'b00, 2'b00, 2'b00);
    addVec(2,  8'h22, 32'h004, 8'd2, 3'b010, 2'b00, 3, 32'hA1, 32'hA1, 32'hA1, 32'h0,              2'b00, 2'b00, 2'b00, 2'b00);
    addVec(3,  8'h23, 32'h004, 8'd2, 3'b010, 2'b11, 3, 32'h0,  32'h0,  32'h0,  32'h0,              2'b10, 2'b10, 2'b10, 2'b00);
    addVec(4,  8'h7E, 32'h3FC, 8'd1, 3'b010, 2'b01, 2, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0,         2'b00, 2'b10, 2'b00, 2'b00);
    addVec(5,  8'h01, 32'h000, 8'd0, 3'b010, 2'b01, 1, 32'hA0, 32'h0,  32'h0,  32'h0,              2'b00, 2'b00, 2'b00, 2'b00);
    addVec(6,  8'h02, 32'h000, 8'd1, 3'b011, 2'b01, 2, 32'h0,  32'h0,  32'h0,  32'h0,              2'b10, 2'b10, 2'b00, 2'b00);
    addVec(7,  8'h03, 32'h000, 8'd2, 3'b010, 2'b10, 3, 32'h0,  32'h0,  32'h0,  32'h0,              2'b10, 2'b10, 2'b10, 2'b00);
    addVec(8,  8'h04, 32'h001, 8'd0, 3'b010, 2'b01, 1, 32'h0,  32'h0,  32'h0,  32'h0,              2'b10, 2'b00, 2'b00, 2'b00);
    addVec(9,  8'h05, 32'h00C, 8'd1, 3'b010, 2'b10, 2, 32'hA3, 32'hA2, 32'h0,  32'h0,              2'b00, 2'b00, 2'b00, 2'b00);
    addVec(10, 8'h06, 32'h004, 8'd0, 3'b010, 2'b01, 1, 32'h9999_0001, 32'h0, 32'h0, 32'h0,        2'b00, 2'b00, 2'b00, 2'b00);
    addVec(11, 8'h07, 32'h008, 8'd0, 3'b010, 2'b01, 1, 32'hA2, 32'h0,  32'h0,  32'h0,              2'b00, 2'b00, 2'b00, 2'b00);

    // Preload while held in reset; the array itself is not reset
    @(posedge ACLK); #1;
    for (int w = 0; w < 4; w++) backdoorWrite(w, 32'hA0 + 32'(w));
    backdoorWrite(DEPTH - 1, 32'hDEAD_BEEF);

    @(negedge ACLK);
    checkOutput("reset arready", ARREADY, 32'd0);
    checkOutput("reset rvalid", RVALID, 32'd0);
    checkOutput("reset rlast", RLAST, 32'd0);
    checkOutput("reset rid", RID, 32'd0);
    checkOutput("reset rdata", RDATA, 32'd0);
    checkOutput("reset rresp", RRESP, 32'd0);
    ARESETn = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Stall sequence: RREADY 1,0,0,1 across a two-beat INCR burst from word 1
    ARVALID = 1'b1; ARID = 8'h33; ARADDR = 32'h4; ARLEN = 8'd1; ARSIZE = 3'b010; ARBURST = 2'b01;
    RREADY  = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("stall b0 rdata", RDATA, 32'hA1);
    checkOutput("stall b0 rlast", RLAST, 32'd0);
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      checkOutput($sformatf("stall hold%0d rvalid", k), RVALID, 32'd1);
      checkOutput($sformatf("stall hold%0d rdata", k), RDATA, 32'hA2);
      checkOutput($sformatf("stall hold%0d rlast", k), RLAST, 32'd1);
      checkOutput($sformatf("stall hold%0d rid", k), RID, 32'h33);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    checkOutput("stall b1 rdata", RDATA, 32'hA2);
    checkOutput("stall b1 rlast", RLAST, 32'd1);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    checkOutput("stall done rvalid", RVALID, 32'd0);

    // Backdoor sequence: a write on the load edge and a write during a stall
    ARVALID = 1'b1; ARID = 8'h44; ARADDR = 32'h0; ARLEN = 8'd1; ARBURST = 2'b01;
    RREADY  = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("bd b0 rdata", RDATA, 32'hA0);
    bd_we = 1'b1; bd_addr = AW'(1); bd_wdata = 32'h1234_5678;
    @(posedge ACLK); #1;
    bd_we = 1'b0; RREADY = 1'b0;
    @(negedge ACLK);
    checkOutput("bd same-edge rdata", RDATA, 32'hA1);
    bd_we = 1'b1; bd_addr = AW'(1); bd_wdata = 32'h9999_0001;
    @(posedge ACLK); #1;
    bd_we = 1'b0;
    @(negedge ACLK);
    checkOutput("bd presented rdata", RDATA, 32'hA1);
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    checkOutput("bd done rvalid", RVALID, 32'd0);
    applyStimulus(vecs[10], 10);

    // Reset mid-burst after two beats have been accepted
    ARVALID = 1'b1; ARID = 8'h55; ARADDR = 32'h0; ARLEN = 8'd3; ARBURST = 2'b01;
    RREADY  = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #2;
    ARESETn = 1'b0;
    #1;
    checkOutput("midrst rvalid", RVALID, 32'd0);
    checkOutput("midrst rlast", RLAST, 32'd0);
    checkOutput("midrst rdata", RDATA, 32'd0);
    checkOutput("midrst arready", ARREADY, 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    applyStimulus(vecs[11], 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/axi_rd_slave_mem.md
Name: axi_rd_slave_mem

Overview:
AXI4 read-channel responder: a memory-backed slave that accepts AR requests and returns R bursts (RID, RDATA, RRESP, RLAST, RVALID).
It sits on the slave side of the interconnect, behind the per-slave read return mux, and serves as the s1/s2 read target in integration benches.
Word-addressed internal array with a backdoor preload port for test setup.

Parameters:
DEPTH, 256, number of 32-bit words in the array (power of two)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
WAIT_CYCLES, 2, idle cycles inserted before each beat (only with RD_SLV_WAIT_EN)

Ports:
ACLK  input  1  clock
ARESETn  input  1  asynchronous active-low reset
ARVALID  input  1  read address valid
ARID  input  8  transaction ID
ARADDR  input  32  start byte address
ARLEN  input  8  beats minus one
ARSIZE  input  3  beat size; only 3'b010 supported
ARBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ARREADY  output  1  address accept
RREADY  input  1  master ready for data
RVALID  output  1  data beat valid
RID  output  8  echoed ARID
RDATA  output  32  beat data
RRESP  output  2  00 OKAY, 10 SLVERR
RLAST  output  1  final beat of burst
bd_we  input  1  backdoor write enable
bd_addr  input  $clog2(DEPTH)  backdoor word index
bd_wdata  input  32  backdoor write data

Behaviour:
- Reset (async, ARESETn=0): ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, FSM->IDLE, beat counter=0. Array contents not reset.
- States: IDLE, BURST (plus WAIT with the macro).
- IDLE: ARREADY=1 and RVALID=0. On ARVALID&ARREADY, latch ARID, ARADDR, ARLEN, ARBURST and the error flag; go to BURST. ARREADY=0 the next cycle.
- First beat latency: AR handshake in cycle N -> RVALID=1 in cycle N+1 with beat 0 loaded.
- BURST: RID, RDATA, RRESP and RLAST are registered and held stable while RVALID&~RREADY.
  - On RVALID&RREADY with RLAST=0: load the next beat for the following cycle; RVALID stays 1 (back-to-back).
  - On RVALID&RREADY with RLAST=1: RVALID=0 and go to IDLE. ARREADY=1 the next cycle, so the next AR handshake comes no earlier than 1 cycle after the last beat.
- RLAST=1 exactly when the beat count equals the latched ARLEN. ARLEN=0 gives a single beat with RLAST=1.
- Address update per accepted beat:
  - FIXED: unchanged.
  - INCR: +4, 32-bit wrap-around allowed.
  - WRAP: +4 within the aligned window of (ARLEN+1)*4 bytes; crossing the top of the window returns to the window base.
- Word index = (addr - BASE_ADDR) >> 2.
- Error handling: the error flag is set at AR time if any of these holds:
  - ARSIZE != 3'b010
  - ARBURST = 2'b11
  - WRAP with ARLEN not in {1,3,7,15}
  - start address unaligned (ARADDR[1:0] != 0)
  If set, every beat returns RRESP=2'b10 and RDATA=0, with full burst length and normal RLAST.
- Per-beat range check: addr < BASE_ADDR or word index >= DEPTH gives RRESP=2'b10 and RDATA=0 for that beat only; other beats are OKAY.
- Backdoor: on bd_we, array[bd_addr] <= bd_wdata at the clock edge. A beat loaded on the same edge reads the pre-write value. Already-presented RDATA never changes.
- ARVALID while in BURST is ignored (ARREADY=0); the master must hold it.
- Reset mid-burst: outputs clear immediately and the remaining beats are discarded.

Optional Feature:
- Macro RD_SLV_WAIT_EN.
- Defined:
  - After the AR handshake and after each non-last beat handshake, the FSM enters WAIT for WAIT_CYCLES cycles with RVALID=0, then presents the beat.
  - First-beat latency becomes 1+WAIT_CYCLES.
  - WAIT_CYCLES=0 behaves as undefined.
- Undefined: no WAIT state; timing exactly as in Behaviour.

Test Plan:
- Preload words 0..3 = 0xA0..0xA3; AR INCR ARADDR=0 ARLEN=3 ARID=0x5C, RREADY=1 -> RVALID at N+1; RDATA A0,A1,A2,A3 on consecutive cycles; RID=0x5C; RRESP=00; RLAST only on the 4th beat; ARREADY=1 the cycle after.
- WRAP ARADDR=0x08 ARLEN=3 -> data from words 2,3,0,1.
- FIXED ARADDR=0x04 ARLEN=2 -> three beats of word 1. Same address with ARBURST=11 -> three beats, RRESP=10, RDATA=0.
- INCR starting at the last word (DEPTH-1) with ARLEN=1 -> beat 0 OKAY, beat 1 SLVERR with RDATA=0 and RLAST=1.
- RREADY toggled 1,0,0,1 during a 2-beat burst -> RDATA/RID/RLAST held constant across stall cycles; no beat lost or duplicated.
- Assert ARESETn=0 mid-burst after beat 1 -> RVALID=0 immediately; after release ARREADY=1 and a new AR is served from beat 0. With RD_SLV_WAIT_EN and WAIT_CYCLES=2 -> 2 idle cycles before every beat.
